// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, opcodes, select-field values and control vector for the multi-cycle MIPS controller
//   state_e : 4-bit FSM state encoding (IDLE=0 .. I_WB=12; 13-15 unused)
//   OP_*    : supported instruction[31:26] opcodes
//   ALU_*, SRCB_*, PCSRC_* : encodings of the alu_op, alu_src_b and pc_source selects
//   ctrl_t  : packed bundle of every datapath select/enable
//   op_legal: true for opcodes the FSM can execute
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       reg_dest;
    logic       reg_write;
  } ctrl_t;
  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction
endpackage

// File: rtl/ctrl_output_decode.sv
// ctrl_output_decode: combinational mapping of FSM state to the datapath control vector
//   state_i     : registered FSM state
//   mem_ready_i : memory handshake, qualifies ir_write/pc_write in FETCH
//   zero_i      : ALU zero flag
//   ctrl_o      : all datapath selects and enables
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   zero_i,
  output ctrl_t  ctrl_o
);
  // Branch resolution happens in the datapath (pc_write_cond gated by zero),
  // so the flag is carried on the interface but not consumed here.
  logic unused_zero;
  assign unused_zero = zero_i;
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dest  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_I_WB: ctrl_o.reg_write = 1'b1;
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multi-cycle MIPS datapath with retired-instruction counter
//   clk, reset (async, active-low)
//   opcode, zero, mem_ready : instruction opcode, ALU zero flag, memory handshake
//   pc_write .. ctrl_reg_write : datapath selects and enables
//   illegal_op : pulse in DECODE for an unsupported opcode
//   retired    : wrapping count of completed instructions
//   state_o    : current state for debug
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               ctrl_reg_dest,
  output logic               ctrl_reg_write,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] retired,
  output logic [3:0]         state_o
);
  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   retired_q, retired_d;
  logic                 retire;
  ctrl_t                ctrl;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end
  // retire marks the final transition of an instruction back into FETCH
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = opcode == OP_RTYPE                   ? S_R_EXEC   :
                  (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                  opcode == OP_BEQ                     ? S_BRANCH   :
                  opcode == OP_J                       ? S_JUMP     :
                  opcode == OP_ADDI                    ? S_I_EXEC   : S_FETCH;
        illegal_op = !op_legal(opcode);
      end
      S_MEM_ADDR:  state_d = opcode == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: begin
        state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
        retire  = mem_ready;
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:     state_d = S_IDLE;
    endcase
  end
  assign retired_d = retired_q + COUNT_W'(retire);
  ctrl_output_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .ctrl_o      (ctrl)
  );
  assign pc_write       = ctrl.pc_write;
  assign pc_write_cond  = ctrl.pc_write_cond;
  assign i_or_d         = ctrl.i_or_d;
  assign mem_read       = ctrl.mem_read;
  assign mem_write      = ctrl.mem_write;
  assign ir_write       = ctrl.ir_write;
  assign mem_to_reg     = ctrl.mem_to_reg;
  assign alu_src_a      = ctrl.alu_src_a;
  assign alu_src_b      = ctrl.alu_src_b;
  assign alu_op         = ctrl.alu_op;
  assign pc_source      = ctrl.pc_source;
  assign ctrl_reg_dest  = ctrl.reg_dest;
  assign ctrl_reg_write = ctrl.reg_write;
  assign retired        = retired_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench driving directed instruction sequences through multicycle_control
module tb_multicycle_control;
  localparam int CW = 4;
  logic          clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0]    opcode = 6'h00;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic          ctrl_reg_dest, ctrl_reg_write, illegal_op;
  logic [CW-1:0] retired;
  logic [3:0]    state_o;
  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, asa;
    logic [1:0] asb, aop, psrc;
    logic       rd, rw;
  } cv_t;
  typedef struct {
    int            n;
    logic [3:0]    st;
    cv_t           cv;
    logic          ill;
    logic [CW-1:0] ret;
  } exp_t;
  exp_t q[$];
  int   errors = 0, checks = 0, n_step = 0;
  cv_t  act;
  multicycle_control #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .ctrl_reg_dest(ctrl_reg_dest),
    .ctrl_reg_write(ctrl_reg_write), .illegal_op(illegal_op),
    .retired(retired), .state_o(state_o)
  );
  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_source, ctrl_reg_dest, ctrl_reg_write};
  always #5 clk = ~clk;
  function automatic cv_t ref_cv(input logic [3:0] st, input logic mr);
    cv_t c;
    c = '0;
    case (st)
      4'd1:  begin c.mrd = 1'b1; c.asb = 2'd1; c.irw = mr; c.pcw = mr; end
      4'd2:  c.asb = 2'd3;
      4'd3:  begin c.asa = 1'b1; c.asb = 2'd2; end
      4'd4:  begin c.mrd = 1'b1; c.iord = 1'b1; end
      4'd5:  begin c.rw = 1'b1; c.m2r = 1'b1; end
      4'd6:  begin c.mwr = 1'b1; c.iord = 1'b1; end
      4'd7:  begin c.asa = 1'b1; c.aop = 2'd2; end
      4'd8:  begin c.rw = 1'b1; c.rd = 1'b1; end
      4'd9:  begin c.asa = 1'b1; c.aop = 2'd1; c.psrc = 2'd1; c.pcwc = 1'b1; end
      4'd10: begin c.pcw = 1'b1; c.psrc = 2'd2; end
      4'd11: begin c.asa = 1'b1; c.asb = 2'd2; end
      4'd12: c.rw = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
  task automatic chk(input string nm, input int n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%h exp=%h", nm, n, got, exp);
    end
  endtask
  // One cycle of stimulus; the expected response for that cycle goes to the scoreboard
  task automatic step(input int r, input int op, input int mr, input int z, input int st, input int ill, input int ret);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = 1'(r);
    opcode    = 6'(op);
    mem_ready = 1'(mr);
    zero      = 1'(z);
    e.n   = n_step++;
    e.st  = 4'(st);
    e.cv  = ref_cv(4'(st), 1'(mr));
    e.ill = 1'(ill);
    e.ret = CW'(ret);
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", e.n, 32'(state_o), 32'(e.st));
      chk("ctrl", e.n, 32'(act), 32'(e.cv));
      chk("illegal_op", e.n, 32'(illegal_op), 32'(e.ill));
      chk("retired", e.n, 32'(retired), 32'(e.ret));
    end
  end
  initial begin
    #1 reset = 1'b0;
    repeat (3) step(0, 'h00, 1, 0, 0, 0, 0);
    step(1, 'h00, 1, 0, 0, 0, 0);
    step(1, 'h00, 1, 0, 1, 0, 0);
    step(1, 'h00, 1, 0, 2, 0, 0);
    step(1, 'h00, 1, 0, 7, 0, 0);
    step(1, 'h00, 1, 0, 8, 0, 0);
    step(1, 'h23, 1, 0, 1, 0, 1);
    step(1, 'h23, 1, 0, 2, 0, 1);
    step(1, 'h23, 1, 0, 3, 0, 1);
    step(1, 'h23, 0, 0, 4, 0, 1);
    step(1, 'h23, 0, 0, 4, 0, 1);
    step(1, 'h23, 1, 0, 4, 0, 1);
    step(1, 'h23, 1, 0, 5, 0, 1);
    repeat (4) step(1, 'h08, 0, 0, 1, 0, 2);
    step(1, 'h08, 1, 0, 1, 0, 2);
    step(1, 'h08, 1, 0, 2, 0, 2);
    step(1, 'h08, 1, 0, 11, 0, 2);
    step(1, 'h08, 1, 0, 12, 0, 2);
    step(1, 'h04, 1, 0, 1, 0, 3);
    step(1, 'h04, 1, 0, 2, 0, 3);
    step(1, 'h04, 1, 1, 9, 0, 3);
    step(1, 'h04, 1, 0, 1, 0, 4);
    step(1, 'h04, 1, 0, 2, 0, 4);
    step(1, 'h04, 1, 0, 9, 0, 4);
    step(1, 'h3F, 1, 0, 1, 0, 5);
    step(1, 'h3F, 1, 0, 2, 1, 5);
    step(1, 'h2B, 1, 0, 1, 0, 5);
    step(1, 'h2B, 0, 0, 2, 0, 5);
    step(1, 'h2B, 0, 0, 3, 0, 5);
    step(1, 'h2B, 0, 0, 6, 0, 5);
    step(1, 'h2B, 1, 0, 6, 0, 5);
    for (int j = 0; j < 10; j++) begin
      step(1, 'h02, 1, 0, 1, 0, 6 + j);
      step(1, 'h02, 1, 0, 2, 0, 6 + j);
      step(1, 'h02, 1, 0, 10, 0, 6 + j);
    end
    step(1, 'h00, 1, 0, 1, 0, 0);
    step(1, 'h00, 1, 0, 2, 0, 0);
    step(1, 'h00, 1, 0, 7, 0, 0);
    step(0, 'h00, 1, 0, 0, 0, 0);
    step(0, 'h00, 1, 0, 0, 0, 0);
    step(1, 'h00, 1, 0, 0, 0, 0);
    step(1, 'h00, 1, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("drain", n_step, 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback, and drives all datapath select and enable lines, including ctrl_reg_dest and ctrl_reg_write into the instruction-decode/register-file stage.
- Stalls on a memory ready handshake, flags illegal opcodes, and counts retired instructions.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  6  instruction[31:26] from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if zero
- i_or_d  output  1  0 = PC addresses memory, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback source is MDR
- alu_src_a  output  1  0 = PC, 1 = reg A
- alu_src_b  output  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = imm<<2
- alu_op  output  2  0 = add, 1 = sub, 2 = funct-decoded
- pc_source  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- ctrl_reg_dest  output  1  1 = rd, 0 = rt
- ctrl_reg_write  output  1  register file write enable
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- retired  output  COUNT_W  instructions completed, wraps
- state_o  output  4  current state, for debug

Behaviour:
- Reset: clk and reset as above. While reset=0: state=IDLE, retired=0, and every control output is 0.
- Outputs: Moore decode of the registered state. The only Mealy qualifiers are mem_ready in FETCH, and mem_ready plus zero where listed below. Every output not listed for a state is 0.
- State encodings and behaviour:
  - IDLE(0): all outputs 0. Next state FETCH.
  - FETCH(1): mem_read=1, alu_src_b=1, alu_op=0, pc_source=0. ir_write and pc_write are asserted only when mem_ready=1. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(2): alu_src_b=3, alu_op=0 (branch target precompute). Next state by opcode:
    - 0x00 -> R_EXEC
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> I_EXEC
    - any other -> FETCH, with illegal_op=1 for that cycle. Not counted as retired.
  - MEM_ADDR(3): alu_src_a=1, alu_src_b=2, alu_op=0. Goes to MEM_READ if opcode=0x23, else MEM_WRITE.
  - MEM_READ(4): mem_read=1, i_or_d=1. Holds until mem_ready=1, then MEM_WB.
  - MEM_WB(5): ctrl_reg_write=1, mem_to_reg=1, ctrl_reg_dest=0. Next state FETCH.
  - MEM_WRITE(6): mem_write=1, i_or_d=1. Holds until mem_ready=1, then FETCH.
  - R_EXEC(7): alu_src_a=1, alu_src_b=0, alu_op=2. Next state R_WB.
  - R_WB(8): ctrl_reg_write=1, ctrl_reg_dest=1, mem_to_reg=0. Next state FETCH.
  - BRANCH(9): alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1, pc_write_cond=1. Next state FETCH.
  - JUMP(10): pc_write=1, pc_source=2. Next state FETCH.
  - I_EXEC(11): alu_src_a=1, alu_src_b=2, alu_op=0. Next state I_WB.
  - I_WB(12): ctrl_reg_write=1, ctrl_reg_dest=0, mem_to_reg=0. Next state FETCH.
  - Encodings 13-15: unreachable; the next state is IDLE.
- Opcode sampling: opcode is sampled every cycle. The IR holds it stable from DECODE until the next FETCH completes.
- Latencies, with mem_ready=1 every cycle:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
- Retired counter: increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or I_WB. Wraps from all-ones to 0.
- Reset mid-operation: an asynchronous return to IDLE. Any write enable (ctrl_reg_write, mem_write, pc_write) drops immediately and combinationally, and no partial instruction is counted.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum (4-bit, encodings above);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - alu_op, alu_src_b and pc_source localparams.
- One sub-module, ctrl_output_decode: purely combinational mapping of state, mem_ready and zero to the control vector. The FSM and counter stay in the top module.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 -> all outputs 0 and state_o=0 during reset. First cycle after release is IDLE; state_o=1 on the next cycle with mem_read=1.
- R-type (opcode 0x00), mem_ready=1 -> states 1,2,7,8,1. ctrl_reg_dest=1 and ctrl_reg_write=1 only in state 8. retired goes 0->1.
- lw (opcode 0x23), mem_ready low for 2 cycles in MEM_READ -> state 4 held 3 cycles. MEM_WB asserts ctrl_reg_write=1, mem_to_reg=1, ctrl_reg_dest=0. Total 7 cycles.
- FETCH with mem_ready=0 for 4 cycles -> ir_write=0 and pc_write=0 throughout. On the cycle mem_ready=1, both are 1 and the next state is DECODE.
- beq (opcode 0x04) with zero=1, then with zero=0 -> pc_write_cond=1 and pc_source=1 in state 9 for both cases. retired increments both times.
- Opcode 0x3F -> illegal_op=1 in DECODE, return to FETCH, retired unchanged. Separately, preload retired to all-ones and retire one instruction -> retired=0.
